mem_arb: RTL
============

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 32, address width; LINE_W, 128, cache line width; TIMEOUT, 255, watchdog cycle limit (used only with MEM_ARB_TIMEOUT_EN).
REQ-002 clk  in  1  rising-edge clock, sole clock domain.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 ic_req  in  1  instruction-cache line-fill request, level, held until ic_fill_valid.
REQ-005 ic_addr  in  ADDR_W  line address for the instruction fill.
REQ-006 dc_req  in  1  data-cache request, level, held until dc_fill_valid.
REQ-007 dc_we  in  1  1 = line write-back, 0 = line fill.
REQ-008 dc_addr  in  ADDR_W  data line address.
REQ-009 dc_wdata  in  LINE_W  write-back data.
REQ-010 ic_stall  out  1  pipeline stall request to the flow controller, instruction side.
REQ-011 dc_stall  out  1  pipeline stall request to the flow controller, data side.
REQ-012 ic_fill_valid / dc_fill_valid  out  1 each  one-cycle completion pulses.
REQ-013 fill_data  out  LINE_W  registered line returned from memory.
REQ-014 mem_req  out  1, mem_we  out  1, mem_addr  out  ADDR_W, mem_wdata  out  LINE_W  memory request channel.
REQ-015 mem_ack  in  1, mem_rdata  in  LINE_W  memory response; rdata valid in the mem_ack cycle.
REQ-016 err  out  1  sticky memory-timeout flag.

Function
REQ-017 FSM states: IDLE, SERVE_IC, SERVE_DC, DONE_IC, DONE_DC.
REQ-018 IDLE: dc_req=1 -> SERVE_DC; else ic_req=1 -> SERVE_IC; else remain in IDLE. Fixed priority, data over instruction.
REQ-019 On leaving IDLE, address, write data and dc_we are captured into registers; mem_req rises in the following cycle.
REQ-020 SERVE_x: mem_req=1 and mem_addr, mem_we and mem_wdata are held stable until mem_ack.
REQ-021 mem_ack in SERVE_x: fill_data <= mem_rdata (reads only; writes leave fill_data unchanged); mem_req=0 from the next cycle; state -> DONE_x.
REQ-022 DONE_x: x_fill_valid=1 for exactly one cycle, then -> IDLE.
REQ-023 ic_stall = ic_req & ~ic_fill_valid; dc_stall = dc_req & ~dc_fill_valid. Both are combinational, so a request stalls the pipeline in the same cycle it is raised.
REQ-024 Minimum latency from req rising to fill_valid is 3 cycles with mem_ack returned the cycle after mem_req.
REQ-025 Simultaneous ic_req and dc_req: data is served first, ic_stall stays 1 throughout, and instruction service starts in the IDLE cycle after DONE_DC.
REQ-026 mem_ack outside SERVE_x is ignored.
REQ-027 A request dropped before completion is still completed on the memory side; its fill_valid still pulses.

Reset
REQ-028 reset_n=0 asynchronously forces: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, fill_data=0, both fill_valid=0, err=0.
REQ-029 Both stalls are forced to 0 while reset_n=0.
REQ-030 Reset during SERVE_x abandons the transaction; a late mem_ack is then ignored under REQ-026.

Configuration
REQ-031 Macro MEM_ARB_TIMEOUT_EN defined: a watchdog counter clears on entry to SERVE_x and increments each SERVE_x cycle without mem_ack.
REQ-032 When the watchdog reaches TIMEOUT: err <= 1 (sticky until reset), fill_data <= 0, state -> DONE_x, mem_req drops.
REQ-033 Macro MEM_ARB_TIMEOUT_EN undefined: no watchdog logic, err is tied to 0, and SERVE_x waits indefinitely for mem_ack.

Verification
REQ-034 ic_req=1, ic_addr=0x100, mem_ack the cycle after mem_req with rdata=0xA5..A5 -> mem_addr=0x100, mem_we=0; ic_fill_valid pulses on cycle 3; fill_data=0xA5..A5; ic_stall is 1 on cycles 0-2 and 0 on cycle 3.
REQ-035 ic_req and dc_req raised in the same cycle (dc_addr=0x200, ic_addr=0x300), mem_ack delay 2 -> memory sees 0x200 first, then 0x300; ic_stall stays high until ic_fill_valid.
REQ-036 dc_req=1, dc_we=1, dc_wdata=0x1234 -> mem_we=1, mem_wdata=0x1234; dc_fill_valid pulses; fill_data is unchanged.
REQ-037 reset_n pulsed low mid-SERVE_DC, then mem_ack asserted -> mem_req=0 immediately; no fill_valid pulse; state is IDLE.
REQ-038 MEM_ARB_TIMEOUT_EN defined, TIMEOUT=4, mem_ack never asserted -> err=1 after 4 SERVE cycles, fill_valid pulses, fill_data=0, and err stays 1 across later requests.

Source files
------------

// File: rtl/mem_arb.sv
// Two-port line-fill arbiter: data cache has fixed priority over instruction cache onto one memory channel.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN (sticky err, zeroed fill on expiry).
module mem_arb #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              ic_stall,
  output logic              dc_stall,
  output logic              ic_fill_valid,
  output logic              dc_fill_valid,
  output logic [LINE_W-1:0] fill_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, SERVE_IC, SERVE_DC, DONE_IC, DONE_DC} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] fill_q, fill_d;
  logic              serving;
  logic              timeout;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_arb: TIMEOUT must be at least 1");
  end

  assign serving = (state_q == SERVE_IC) || (state_q == SERVE_DC);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            err_q, err_d;

  // Fires on the TIMEOUT-th consecutive serve cycle without an ack.
  assign timeout = serving && !mem_ack && (wdog_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    wdog_d = wdog_q;
    err_d  = err_q | timeout;
    if (state_q == IDLE) begin
      wdog_d = '0;
    end else if (serving && !mem_ack) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE: begin
        if (dc_req) begin
          state_d = SERVE_DC;
          addr_d  = dc_addr;
          we_d    = dc_we;
          wdata_d = dc_wdata;
        end else if (ic_req) begin
          state_d = SERVE_IC;
          addr_d  = ic_addr;
          we_d    = 1'b0;
        end
      end
      SERVE_IC, SERVE_DC: begin
        if (mem_ack || timeout) begin
          state_d = (state_q == SERVE_IC) ? DONE_IC : DONE_DC;
          // Write-backs return nothing, so the last fill line is kept.
          if (mem_ack) begin
            if (!we_q) fill_d = mem_rdata;
          end else begin
            fill_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      fill_q  <= fill_d;
    end
  end

  assign mem_req       = serving;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign fill_data     = fill_q;
  assign ic_fill_valid = (state_q == DONE_IC);
  assign dc_fill_valid = (state_q == DONE_DC);

  // Stalls are combinational so a new request holds the pipeline in its first cycle.
  assign ic_stall = reset_n & ic_req & ~ic_fill_valid;
  assign dc_stall = reset_n & dc_req & ~dc_fill_valid;

endmodule
